// File: rtl/ws2812_rx.sv
// ws2812_rx: receive-side decoder for the WS2812 one-wire protocol.
// Measures each high pulse on din, classifies it as a 0 or 1, assembles bits
// MSB-first into 24-bit GRB pixels and closes the frame on the latch gap.
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous, active-low reset
//   din            in   WS2812 serial line (asynchronous, synchronized here)
//   px_data        out  last decoded pixel, GRB, first received bit = bit 23
//   px_index       out  index of px_data within the current frame
//   px_valid       out  1-cycle strobe, px_data/px_index are new
//   frame_done     out  1-cycle strobe, latch gap seen, frame closed
//   frame_px_count out  complete pixels in the closed frame (saturates at MAX_PX)
//   frame_err      out  closed frame had an error, valid with frame_done
//   busy           out  high from the first rising edge of a frame to frame_done
//   err_count      out  (WS_RX_STATS_EN only) saturating count of errored frames
//   frame_count    out  (WS_RX_STATS_EN only) wrapping count of closed frames
//
// Build option: define WS_RX_STATS_EN to add the err_count/frame_count ports.
//
// State table:
//   SYNC    | waiting for a full latch gap before decoding anything
//   IDLE    | line quiet, waiting for the first rising edge of a frame
//   HIGH    | measuring a high pulse
//   LOW     | between bits, waiting for the next rise or the latch gap
//   DISCARD | frame is bad, ignoring edges until the latch gap
module ws2812_rx #(
    parameter int T_MIN_HIGH     = 20,
    parameter int BIT_THRESH     = 60,
    parameter int T_MAX_HIGH     = 120,
    parameter int RESET_CYCLES   = 5000,
    parameter int MAX_PX         = 52,
    parameter int PX_COUNT_WIDTH = 6,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      din,
    output logic [23:0]               px_data,
    output logic [PX_COUNT_WIDTH-1:0] px_index,
    output logic                      px_valid,
    output logic                      frame_done,
    output logic [PX_COUNT_WIDTH-1:0] frame_px_count,
    output logic                      frame_err,
    output logic                      busy
`ifdef WS_RX_STATS_EN
    ,
    output logic [7:0]                err_count,
    output logic [15:0]               frame_count
`endif
);

    localparam logic [CNT_WIDTH-1:0]      T_GAP  = CNT_WIDTH'(RESET_CYCLES);
    localparam logic [CNT_WIDTH-1:0]      T_MIN  = CNT_WIDTH'(T_MIN_HIGH);
    localparam logic [CNT_WIDTH-1:0]      T_THR  = CNT_WIDTH'(BIT_THRESH);
    localparam logic [CNT_WIDTH-1:0]      T_MAX  = CNT_WIDTH'(T_MAX_HIGH);
    localparam logic [PX_COUNT_WIDTH-1:0] PX_MAX = PX_COUNT_WIDTH'(MAX_PX);

    typedef enum logic [2:0] {S_SYNC, S_IDLE, S_HIGH, S_LOW, S_DISCARD} state_t;

    state_t                      state_q, state_d;
    logic                        sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [CNT_WIDTH-1:0]        t_q, t_d;
    logic [4:0]                  bit_cnt_q, bit_cnt_d;
    logic [PX_COUNT_WIDTH-1:0]   px_cnt_q, px_cnt_d;
    logic                        err_q, err_d;
    logic [23:0]                 shift_q, shift_d;
    logic                        busy_q, busy_d;
    logic [23:0]                 px_data_q, px_data_d;
    logic [PX_COUNT_WIDTH-1:0]   px_index_q, px_index_d;
    logic                        px_valid_q, px_valid_d;
    logic                        frame_done_q, frame_done_d;
    logic [PX_COUNT_WIDTH-1:0]   frame_px_count_q, frame_px_count_d;
    logic                        frame_err_q, frame_err_d;
`ifdef WS_RX_STATS_EN
    logic [7:0]                  err_count_q, err_count_d;
    logic [15:0]                 frame_count_q, frame_count_d;
`endif

    logic din_s, rise, fall, at_gap, bit_val;

    assign din_s = sync2_q;
    assign rise  = din_s & ~prev_q;
    assign fall  = ~din_s & prev_q;
    // On an edge cycle t_q still holds the previous level's length, so the
    // gap is only recognised once the line has been low with no edge pending.
    assign at_gap = ~din_s & ~prev_q & (t_q == T_GAP);

    always_comb begin
        sync1_d          = din;
        sync2_d          = sync1_q;
        prev_d           = din_s;
        t_d              = (rise | fall) ? '0 : ((t_q == T_GAP) ? t_q : t_q + 1'b1);
        state_d          = state_q;
        bit_cnt_d        = bit_cnt_q;
        px_cnt_d         = px_cnt_q;
        err_d            = err_q;
        shift_d          = shift_q;
        busy_d           = busy_q;
        px_data_d        = px_data_q;
        px_index_d       = px_index_q;
        px_valid_d       = 1'b0;
        frame_done_d     = 1'b0;
        frame_px_count_d = frame_px_count_q;
        frame_err_d      = frame_err_q;
        bit_val          = (t_q >= T_THR);

        case (state_q)
            S_SYNC: begin
                if (at_gap) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (rise) begin
                    state_d   = S_HIGH;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                    px_cnt_d  = '0;
                    err_d     = 1'b0;
                end
            end
            S_HIGH: begin
                if (t_q > T_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_DISCARD;
                end else if (fall) begin
                    if (t_q < T_MIN) begin
                        err_d   = 1'b1;
                        state_d = S_DISCARD;
                    end else begin
                        shift_d = {shift_q[22:0], bit_val};
                        state_d = S_LOW;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = '0;
                            if (px_cnt_q < PX_MAX) begin
                                px_valid_d = 1'b1;
                                px_data_d  = shift_d;
                                px_index_d = px_cnt_q;
                                px_cnt_d   = px_cnt_q + 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
            end
            S_LOW: begin
                if (rise) begin
                    state_d = S_HIGH;
                end else if (at_gap) begin
                    frame_done_d     = 1'b1;
                    frame_px_count_d = px_cnt_q;
                    frame_err_d      = err_q | (bit_cnt_q != 5'd0);
                    busy_d           = 1'b0;
                    state_d          = S_IDLE;
                end
            end
            S_DISCARD: begin
                if (at_gap) begin
                    frame_done_d     = 1'b1;
                    frame_px_count_d = px_cnt_q;
                    frame_err_d      = 1'b1;
                    busy_d           = 1'b0;
                    state_d          = S_IDLE;
                end
            end
            default: state_d = S_SYNC;
        endcase

`ifdef WS_RX_STATS_EN
        err_count_d   = err_count_q;
        frame_count_d = frame_count_q;
        if (frame_done_d) begin
            frame_count_d = frame_count_q + 1'b1;
            if (frame_err_d && (err_count_q != 8'hFF)) err_count_d = err_count_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= S_SYNC;
            sync1_q          <= 1'b0;
            sync2_q          <= 1'b0;
            prev_q           <= 1'b0;
            t_q              <= '0;
            bit_cnt_q        <= '0;
            px_cnt_q         <= '0;
            err_q            <= 1'b0;
            shift_q          <= '0;
            busy_q           <= 1'b0;
            px_data_q        <= '0;
            px_index_q       <= '0;
            px_valid_q       <= 1'b0;
            frame_done_q     <= 1'b0;
            frame_px_count_q <= '0;
            frame_err_q      <= 1'b0;
`ifdef WS_RX_STATS_EN
            err_count_q      <= '0;
            frame_count_q    <= '0;
`endif
        end else begin
            state_q          <= state_d;
            sync1_q          <= sync1_d;
            sync2_q          <= sync2_d;
            prev_q           <= prev_d;
            t_q              <= t_d;
            bit_cnt_q        <= bit_cnt_d;
            px_cnt_q         <= px_cnt_d;
            err_q            <= err_d;
            shift_q          <= shift_d;
            busy_q           <= busy_d;
            px_data_q        <= px_data_d;
            px_index_q       <= px_index_d;
            px_valid_q       <= px_valid_d;
            frame_done_q     <= frame_done_d;
            frame_px_count_q <= frame_px_count_d;
            frame_err_q      <= frame_err_d;
`ifdef WS_RX_STATS_EN
            err_count_q      <= err_count_d;
            frame_count_q    <= frame_count_d;
`endif
        end
    end

    assign px_data        = px_data_q;
    assign px_index       = px_index_q;
    assign px_valid       = px_valid_q;
    assign frame_done     = frame_done_q;
    assign frame_px_count = frame_px_count_q;
    assign frame_err      = frame_err_q;
    assign busy           = busy_q;
`ifdef WS_RX_STATS_EN
    assign err_count      = err_count_q;
    assign frame_count    = frame_count_q;
`endif

endmodule
